// File: rtl/keypad_scan_encoder.sv
// rtl/keypad_scan_encoder.sv - 4x4 matrix keypad scanner, frame debouncer and key encoder
//
// Drives one keypad row low at a time, samples the columns at the end of each
// row slot, and debounces whole 16-key frames. A press is reported once as a
// 4-bit code (4*row + col, lowest index wins). A new report requires a full
// release first.
//
// Ports:
//   clk        clock, rising edge
//   clr        reset, asynchronous, active-high
//   col_n[3:0] keypad columns, active-low, asynchronous to clk, pulled up
//   row_n[3:0] keypad row drive, active-low, exactly one bit low
//   key[3:0]   code of the last reported key
//   key_valid  one-cycle pulse per reported press
//   key_held   high from the report until the debounced release
//   keys[15:0] debounced pressed-key vector, bit 4*row + col
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 128
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] keys
);

  localparam int SW  = $clog2(SCAN_DIV);
  localparam int STW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [STW-1:0] STAB_MAX  = STW'(DEBOUNCE);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     sync1_q, sync1_d;
  logic [3:0]     sync2_q, sync2_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [1:0]     row_q, row_d;
  logic [15:0]    snap_q, snap_d;
  logic [15:0]    prev_q, prev_d;
  logic [STW-1:0] stab_q, stab_d;
  logic [15:0]    keys_q, keys_d;
  logic [3:0]     key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           key_held_q, key_held_d;

  logic           sample;
  logic           frame_end;
  logic           stable;
  logic [15:0]    snap_full;
  logic [3:0]     low_idx;

  // Last cycle of each row slot: the columns have had SCAN_DIV-3 cycles
  // to settle through the synchronizer since the row switched.
  assign sample    = (slot_q == SLOT_LAST);
  assign frame_end = sample && (row_q == 2'd3);

  // Snapshot as it will look after this cycle's sample; at frame end this
  // already holds row 3, so the debounce compares a complete frame.
  always_comb begin
    snap_full = snap_q;
    if (sample) begin
      snap_full[{row_q, 2'b00} +: 4] = ~sync2_q;
    end
  end

  // Lowest set bit wins when several keys are down together.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap_full[i]) begin
        low_idx = 4'(i);
      end
    end
  end

  always_comb begin
    row_n = ~(4'b0001 << row_q);
  end

  always_comb begin
    sync1_d     = col_n;
    sync2_d     = sync1_q;
    slot_d      = slot_q + SW'(1);
    row_d       = row_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    keys_d      = keys_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    state_d     = state_q;
    stable      = 1'b0;

    if (sample) begin
      slot_d = '0;
      row_d  = row_q + 2'd1;
      snap_d = snap_full;
    end

    if (frame_end) begin
      if (snap_full == prev_q) begin
        if (stab_q != STAB_MAX) begin
          stab_d = stab_q + STW'(1);
        end
      end else begin
        stab_d = '0;
      end
      prev_d = snap_full;
      stable = (stab_d == STAB_MAX);

      if (stable) begin
        keys_d = snap_full;
        case (state_q)
          IDLE: begin
            if (snap_full != '0) begin
              state_d     = PRESSED;
              key_d       = low_idx;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end
          PRESSED: begin
            // Other keys changing while held only update keys; no rollover.
            if (snap_full == '0) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      slot_q      <= '0;
      row_q       <= 2'd0;
      snap_q      <= '0;
      prev_q      <= '0;
      stab_q      <= '0;
      keys_q      <= '0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      slot_q      <= slot_d;
      row_q       <= row_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      keys_q      <= keys_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign keys      = keys_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb/tb_keypad_scan_encoder.sv - directed bench for keypad_scan_encoder
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;
  logic [15:0] press = 16'h0000;

  int total = 0;
  int bad   = 0;
  int n;
  int pulse_cnt;
  int first_pulse_n;
  int fall_n;
  logic prev_valid;
  logic prev_held;
  logic double_pulse;

  keypad_scan_encoder #(
    .SCAN_DIV(4),
    .DEBOUNCE(2)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held),
    .keys     (keys)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (press[4*r+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  // Rising edges since reset release; frame ends fall on multiples of 16.
  always @(posedge clk or posedge clr) begin
    if (clr) n <= 0;
    else     n <= n + 1;
  end

  task automatic clear_stats();
    pulse_cnt     = 0;
    first_pulse_n = -1;
    fall_n        = -1;
    prev_valid    = 1'b0;
    prev_held     = key_held;
    double_pulse  = 1'b0;
  endtask

  task automatic run_until(input int stop_n);
    int guard;
    guard = 0;
    while (n < stop_n) begin
      @(negedge clk);
      if (key_valid) begin
        if (pulse_cnt == 0) first_pulse_n = n;
        pulse_cnt++;
        if (prev_valid) double_pulse = 1'b1;
      end
      if (prev_held && !key_held && fall_n < 0) fall_n = n;
      prev_valid = key_valid;
      prev_held  = key_held;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL run_timeout: n=%0d required=%0d", n, stop_n);
        return;
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] p);
    @(negedge clk);
    clr   = 1'b1;
    press = p;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    @(negedge clk);
    clr = 1'b1;
    press = 16'h0000;
    @(negedge clk);
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL rst_row_n: got %b required 1110", row_n); end
    total++; if (key !== 4'd0) begin bad++; $display("FAIL rst_key: got %0d required 0", key); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_key_valid: got %b required 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rst_key_held: got %b required 0", key_held); end
    total++; if (keys !== 16'h0000) begin bad++; $display("FAIL rst_keys: got %h required 0000", keys); end
    clr = 1'b0;
    clear_stats();
    for (int i = 0; i < 32; i++) begin
      exp_row = 4'b1111;
      exp_row[(i / 4) % 4] = 1'b0;
      total++;
      if (row_n !== exp_row) begin
        bad++;
        $display("FAIL scan_row_n: cycle %0d got %b required %b", i, row_n, exp_row);
      end
      run_until(i + 1);
    end
    run_until(64);
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL idle_pulses: got %0d required 0", pulse_cnt); end
  endtask

  task automatic test_single_press();
    do_reset(16'h0040);
    run_until(64);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL press_pulses: got %0d required 1", pulse_cnt); end
    total++; if (first_pulse_n !== 48) begin bad++; $display("FAIL press_latency: got %0d required 48", first_pulse_n); end
    total++; if (key !== 4'd6) begin bad++; $display("FAIL press_key: got %0d required 6", key); end
    total++; if (keys !== 16'h0040) begin bad++; $display("FAIL press_keys: got %h required 0040", keys); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b required 1", key_held); end
    total++; if (double_pulse !== 1'b0) begin bad++; $display("FAIL press_double: got %b required 0", double_pulse); end
  endtask

  task automatic test_release();
    clear_stats();
    press = 16'h0000;
    run_until(128);
    total++; if (fall_n !== 112) begin bad++; $display("FAIL release_latency: got %0d required 112", fall_n); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b required 0", key_held); end
    total++; if (keys !== 16'h0000) begin bad++; $display("FAIL release_keys: got %h required 0000", keys); end
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL release_pulses: got %0d required 0", pulse_cnt); end
    total++; if (key !== 4'd6) begin bad++; $display("FAIL release_key: got %0d required 6", key); end
  endtask

  task automatic test_bounce();
    do_reset(16'h0000);
    for (int f = 0; f < 10; f++) begin
      press = (f % 2 == 0) ? 16'h8000 : 16'h0000;
      run_until(16 * (f + 1));
    end
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL bounce_pulses: got %0d required 0", pulse_cnt); end
    press = 16'h8000;
    run_until(224);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL bounce_hold_pulses: got %0d required 1", pulse_cnt); end
    total++; if (first_pulse_n !== 208) begin bad++; $display("FAIL bounce_latency: got %0d required 208", first_pulse_n); end
    total++; if (key !== 4'd15) begin bad++; $display("FAIL bounce_key: got %0d required 15", key); end
  endtask

  task automatic test_multi_press();
    do_reset(16'h0208);
    run_until(64);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL multi_pulses: got %0d required 1", pulse_cnt); end
    total++; if (key !== 4'd3) begin bad++; $display("FAIL multi_key: got %0d required 3", key); end
    total++; if (keys !== 16'h0208) begin bad++; $display("FAIL multi_keys: got %h required 0208", keys); end
    clear_stats();
    press = 16'h0200;
    run_until(128);
    total++; if (keys !== 16'h0200) begin bad++; $display("FAIL rollover_keys: got %h required 0200", keys); end
    total++; if (pulse_cnt !== 0) begin bad++; $display("FAIL rollover_pulses: got %0d required 0", pulse_cnt); end
    total++; if (key !== 4'd3) begin bad++; $display("FAIL rollover_key: got %0d required 3", key); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL rollover_held: got %b required 1", key_held); end
  endtask

  task automatic test_reset_mid_press();
    do_reset(16'h0040);
    run_until(70);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL midrst_pre_held: got %b required 1", key_held); end
    #2 clr = 1'b1;
    #1;
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL midrst_row_n: got %b required 1110", row_n); end
    total++; if (key !== 4'd0) begin bad++; $display("FAIL midrst_key: got %0d required 0", key); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL midrst_held: got %b required 0", key_held); end
    total++; if (keys !== 16'h0000) begin bad++; $display("FAIL midrst_keys: got %h required 0000", keys); end
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    clear_stats();
    run_until(64);
    total++; if (pulse_cnt !== 1) begin bad++; $display("FAIL midrst_pulses: got %0d required 1", pulse_cnt); end
    total++; if (first_pulse_n !== 48) begin bad++; $display("FAIL midrst_latency: got %0d required 48", first_pulse_n); end
    total++; if (key !== 4'd6) begin bad++; $display("FAIL midrst_rekey: got %0d required 6", key); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_multi_press();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

Scans a 4x4 matrix keypad and encodes the debounced keypress into a 4-bit key code for the clock's time-setting logic. It is the inverse of the one-hot 4-to-16 decoder:
- key code k corresponds to one-hot bit k (k = 4*row + col).
- The debounced 16-bit key vector uses the same bit mapping.

The block sits between the DE2 GPIO keypad pins and the time/date set controller. It emits one `key_valid` pulse per press.

## Interface
- `SCAN_DIV`, 1000: clk cycles per row slot; legal range ≥ 4.
- `DEBOUNCE`, 128: count of consecutive identical frame snapshots required beyond the first; legal range ≥ 1.
- `clk` in 1: clock. Positive-edge active.
- `clr` in 1: reset, asynchronous, active-high. Clears all state.
- `col_n` in 4: keypad column inputs, active-low, asynchronous to `clk`, externally pulled up.
- `row_n` out 4: keypad row drive, active-low. Exactly one bit is low at any time.
- `key` out 4: code of the last reported key, 4*row + col.
- `key_valid` out 1: one-cycle pulse when a new press is reported.
- `key_held` out 1: high from the report until the debounced release.
- `keys` out 16: debounced pressed-key vector; bit 4*r+c is set when key (r,c) is pressed.

## Operation
- Synchronizer: `col_n` passes through 2 flops, both reset to 4'b1111. A pressed key in column c reads as synced `col_n[c] == 0`.
- Slot counter:
  - Runs 0..SCAN_DIV-1, then wraps and advances the row index 0→1→2→3→0.
  - `row_n[r]` is low while the row index equals r.
  - Row 0 is driven out of reset.
- Sampling:
  - On slot cycle SCAN_DIV-1 of row r, write the inverted synced `col_n` into snapshot bits [4r+3:4r].
  - Bit 4r+c of the snapshot corresponds to column c.
- Frame end is the sample cycle of row 3. At frame end, using the complete 16-bit snapshot `snap`:
  - If `snap == prev`: increment `stab`, saturating at DEBOUNCE. Otherwise clear `stab` to 0.
  - Update `prev` to `snap`.
  - "Stable" means `stab` equals DEBOUNCE after this update.
  - When stable, copy `snap` into `keys`.
- FSM states IDLE and PRESSED:
  - IDLE → PRESSED at a stable frame end with `snap != 0`.
    - Load `key` with the lowest set bit index of `snap` (priority encoder; lowest index wins on multi-press).
    - Pulse `key_valid`.
    - Set `key_held`.
  - PRESSED → IDLE at a stable frame end with `snap == 0`. Clear `key_held`. `key` keeps its value.
  - In PRESSED, a stable nonzero snapshot that differs from the reported key does not change `key` and produces no pulse. `keys` still updates. No rollover: a new report requires a full release first.
  - IDLE with stable `snap == 0`: no action.
- Arithmetic:
  - Slot counter width is $clog2(SCAN_DIV).
  - `stab` width is $clog2(DEBOUNCE+1).
  - All counters are unsigned and wrap only as described above.

## Timing
- Reset values:
  - `row_n` = 4'b1110
  - `key` = 0, `key_valid` = 0, `key_held` = 0, `keys` = 0
  - slot = 0, row index = 0
  - `stab` = 0, `prev` = 0, snapshot = 0
  - state IDLE
- Frame period = 4*SCAN_DIV cycles.
- A column change takes 2 cycles to reach the synchronizer output. Sampling at slot end therefore gives at least SCAN_DIV-3 settle cycles after the row switch.
- `key`, `key_valid`, `key_held` and `keys` are registered. They update on the cycle after the frame-end edge that makes the frame stable.
- Press latency is DEBOUNCE+1 identical frames, then 1 cycle. Release latency is the same.
- `key_valid` is high for exactly one cycle per press and is never high on two consecutive cycles.
- A bounce (differing snapshot) at any frame end clears `stab` and restarts the count.
- `clr` mid-scan:
  - All outputs return to their reset values immediately.
  - After release, scanning restarts at row 0, slot 0.
  - A key held through reset is reported again after the debounce period.

## Test plan
All scenarios use `SCAN_DIV=4`, `DEBOUNCE=2` (frame = 16 cycles). The bench keypad model drives `col_n[c]` = AND over r of ~(press[r][c] & ~`row_n[r]`).
- Reset and scan: assert `clr`, then release with no keys pressed. Required:
  - all outputs at reset values;
  - `row_n` follows 1110, 1101, 1011, 0111, each held 4 cycles, then repeats;
  - `key_valid` never pulses.
- Single press: press (1,2) before a frame start and hold it. Required:
  - exactly one `key_valid` pulse, 1 cycle after the 3rd identical frame end;
  - `key` = 6, `keys` = 16'h0040, `key_held` = 1.
- Release: release key 6 and hold released. Required:
  - `key_held` falls and `keys` = 0 one cycle after the 3rd zero frame end;
  - no `key_valid` pulse; `key` stays 6.
- Bounce: toggle (3,3) on alternating frames for 10 frames, then hold it. Required:
  - no pulse during the toggling;
  - one pulse with `key` = 15 only after 3 identical frames.
- Multi-press and no-rollover:
  - Press (2,1) and (0,3) together. Required: `key` = 3, `keys` = 16'h0208.
  - Then release (0,3) while (2,1) stays held. Required: `keys` = 16'h0200, no new pulse, `key` = 3.
- Reset mid-press: assert `clr` while key 6 is held in PRESSED. Required:
  - outputs clear immediately;
  - after release of `clr`, one new pulse with `key` = 6 after the debounce period.
